fifo_asymmetric_ratio: RTL

- Parametrised successor to the fixed 8-in/16-out asymmetric FIFO.
- Single-clock FIFO that packs or unpacks data between any power-of-two write and read widths, in either direction (up- or down-conversion).
- Adds an occupancy count, programmable almost-full/almost-empty margins, a synchronous flush, and sticky overflow/underflow flags.
- Sits between DMA/stream producers and PE-array consumers whose bus widths differ.

---
 rtl/fifo_asymmetric_ratio.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_asymmetric_ratio.sv
// Single-clock asymmetric-width FIFO. Packs narrow writes into wide reads,
// or unpacks wide writes into narrow reads. Storage is an array of MIN_W-bit
// units. Provides an occupancy count, almost-full and almost-empty flags,
// a synchronous flush, and sticky overflow and underflow flags.
module fifo_asymmetric_ratio #(
    parameter int unsigned WR_DATA_WIDTH = 8,
    parameter int unsigned RD_DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH    = 4,
    parameter int unsigned AF_MARGIN     = 4,
    parameter int unsigned AE_MARGIN     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     w_req,
    input  logic [WR_DATA_WIDTH-1:0] write_data,
    output logic                     w_ready,
    input  logic                     r_req,
    output logic [RD_DATA_WIDTH-1:0] read_data,
    output logic                     r_ready,
    output logic [ADDR_WIDTH:0]      fifo_count,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow_err,
    output logic                     underflow_err
);

    localparam int unsigned MIN_W = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH;
    localparam int unsigned MAX_W = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? RD_DATA_WIDTH : WR_DATA_WIDTH;
    localparam int unsigned WU    = WR_DATA_WIDTH / MIN_W;
    localparam int unsigned RU    = RD_DATA_WIDTH / MIN_W;
    localparam int unsigned RATIO = MAX_W / MIN_W;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    // Elaboration-time sanity checks on the width and capacity parameters.
    if (MAX_W % MIN_W != 0) begin : g_chk_div
        $error("fifo_asymmetric_ratio: wider width must be a multiple of narrower width");
    end
    if ((RATIO & (RATIO - 1)) != 0 || RATIO > 16) begin : g_chk_ratio
        $error("fifo_asymmetric_ratio: width ratio must be a power of two in 1..16");
    end
    if (DEPTH % RATIO != 0) begin : g_chk_depth
        $error("fifo_asymmetric_ratio: capacity must be a multiple of the width ratio");
    end

    logic [MIN_W-1:0]         mem [DEPTH];
    logic [ADDR_WIDTH-1:0]    wr_ptr;
    logic [ADDR_WIDTH-1:0]    rd_ptr;
    logic [CW-1:0]            free_c;
    logic                     wr_fire_c;
    logic                     rd_fire_c;
    logic [CW-1:0]            count_next_c;
    logic [RD_DATA_WIDTH-1:0] rd_word_c;

    // Status flags derived only from the registered count (no bypass).
    always_comb begin
        free_c       = CW'(DEPTH) - fifo_count;
        w_ready      = free_c >= CW'(WU);
        r_ready      = fifo_count >= CW'(RU);
        almost_full  = 32'(free_c) <= AF_MARGIN;
        almost_empty = 32'(fifo_count) <= AE_MARGIN;
    end

    // Transfer qualification and next occupancy; reset and flush suppress both.
    always_comb begin
        wr_fire_c    = w_req & w_ready & reset & ~flush;
        rd_fire_c    = r_req & r_ready & reset & ~flush;
        count_next_c = fifo_count
                     + (wr_fire_c ? CW'(WU) : CW'(0))
                     - (rd_fire_c ? CW'(RU) : CW'(0));
    end

    // Gather RU consecutive units starting at rd_ptr, oldest unit in the LSBs.
    always_comb begin
        rd_word_c = '0;
        for (int k = 0; k < int'(RU); k++) begin
            rd_word_c[k*MIN_W +: MIN_W] = mem[rd_ptr + ADDR_WIDTH'(k)];
        end
    end

    // Scatter the write word into WU consecutive units, LSB slice first.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            for (int k = 0; k < int'(WU); k++) begin
                mem[wr_ptr + ADDR_WIDTH'(k)] <= write_data[k*MIN_W +: MIN_W];
            end
        end
    end

    // Pointers, count, read register and sticky error flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            read_data     <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (wr_fire_c) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(WU);
            end
            if (rd_fire_c) begin
                rd_ptr    <= rd_ptr + ADDR_WIDTH'(RU);
                read_data <= rd_word_c;
            end
            fifo_count <= count_next_c;
            if (w_req && !w_ready) begin
                overflow_err <= 1'b1;
            end
            if (r_req && !r_ready) begin
                underflow_err <= 1'b1;
            end
        end
    end

endmodule
